// File: rtl/stopwatch_time_core_if.sv
// Stopwatch time core bus.
// Groups the debounced button pulses, the clock-enable ticks, the adjust
// controls and the displayed time/status that leave the core.
//   pause_p, clr_p       : single-cycle debounced button pulses
//   tick_1hz, tick_2hz   : single-cycle clock-enable ticks
//   adj, sel             : adjust-mode switch and field select (0 = min, 1 = sec)
//   min_t, min_o         : minutes tens/ones, BCD
//   sec_t, sec_o         : seconds tens/ones, BCD
//   running              : 1 = RUN, 0 = PAUSED
//   rollover             : one-cycle pulse on a 59:59 -> 00:00 count wrap
// The master side (button/tick logic or a testbench) drives the controls.
// The slave side (the time core) drives the time and status.
interface stopwatch_time_core_if;
  logic       pause_p;
  logic       clr_p;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       adj;
  logic       sel;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       rollover;

  modport master (
    output pause_p, clr_p, tick_1hz, tick_2hz, adj, sel,
    input  min_t, min_o, sec_t, sec_o, running, rollover
  );

  modport slave (
    input  pause_p, clr_p, tick_1hz, tick_2hz, adj, sel,
    output min_t, min_o, sec_t, sec_o, running, rollover
  );
endinterface

// File: rtl/stopwatch_time_core.sv
// Stopwatch time core.
// Keeps the MM:SS time as four BCD digits (00:00 .. 59:59) and a run/pause
// state. In normal mode the time advances on tick_1hz while running. In
// adjust mode the selected field advances on tick_2hz and wraps without carry.
// Ports:
//   clk   : system clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stopwatch_time_core_if.slave, carrying the controls in and the time out
module stopwatch_time_core #(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stopwatch_time_core_if.slave  bus
);

  localparam logic [3:0] TENS_MAX = 4'(MAX_TENS);
  localparam logic [3:0] ONES_MAX = 4'(MAX_ONES);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic       rollover;
  logic       sec_at_max;
  logic       min_at_max;

  // Advance a two-digit BCD field by one and wrap at the field maximum.
  function automatic logic [7:0] inc_field(input logic [3:0] tens,
                                           input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = tens;
    o = ones;
    if (ones == ONES_MAX) begin
      o = 4'd0;
      t = (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
    end else begin
      o = ones + 4'd1;
    end
    return {t, o};
  endfunction

  assign sec_at_max = (sec_t == TENS_MAX) && (sec_o == ONES_MAX);
  assign min_at_max = (min_t == TENS_MAX) && (min_o == ONES_MAX);

  // The run/pause toggle ignores adj and clr_p. The digit block below samples
  // the state from before this edge, so a pause in the same cycle as a tick
  // still uses the old state for the increment decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PAUSED;
    end else if (bus.pause_p) begin
      state <= (state == RUN) ? PAUSED : RUN;
    end
  end

  // The digit update applies clear first, then adjust, then the normal count.
  // rollover defaults low so that it only pulses for the single wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_t    <= 4'd0;
      min_o    <= 4'd0;
      sec_t    <= 4'd0;
      sec_o    <= 4'd0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (bus.clr_p) begin
        min_t <= 4'd0;
        min_o <= 4'd0;
        sec_t <= 4'd0;
        sec_o <= 4'd0;
      end else if (bus.adj) begin
        if (bus.tick_2hz) begin
          if (bus.sel) begin
            {sec_t, sec_o} <= inc_field(sec_t, sec_o);
          end else begin
            {min_t, min_o} <= inc_field(min_t, min_o);
          end
        end
      end else if ((state == RUN) && bus.tick_1hz) begin
        {sec_t, sec_o} <= inc_field(sec_t, sec_o);
        if (sec_at_max) begin
          {min_t, min_o} <= inc_field(min_t, min_o);
          if (min_at_max) begin
            rollover <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.min_t    = min_t;
  assign bus.min_o    = min_o;
  assign bus.sec_t    = sec_t;
  assign bus.sec_o    = sec_o;
  assign bus.running  = state;
  assign bus.rollover = rollover;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Testbench for stopwatch_time_core.
// Uses directed scenarios with hand-computed MM:SS values. The time is
// compared as a 16-bit BCD word, so 16'h0115 means 01:15.
module tb_stopwatch_time_core;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   pass_cnt;

  stopwatch_time_core_if bus();

  stopwatch_time_core #(
    .MAX_TENS(5),
    .MAX_ONES(9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the displayed digits into a single BCD word.
  function automatic logic [15:0] shown();
    return {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o};
  endfunction

  // Drives one cycle of pulses and clears them on the next falling edge.
  // The outputs are sampled on falling edges, well away from the rising edge.
  task automatic applyStimulus(input logic p, input logic c,
                               input logic t1, input logic t2);
    @(negedge clk);
    bus.pause_p  = p;
    bus.clr_p    = c;
    bus.tick_1hz = t1;
    bus.tick_2hz = t2;
    @(negedge clk);
    bus.pause_p  = 1'b0;
    bus.clr_p    = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.tick_2hz = 1'b0;
  endtask

  // Issues n separate 1 Hz ticks.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Issues n separate 2 Hz ticks.
  task automatic run_ticks_2hz(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Holds reset for three clocks and releases it away from a rising edge.
  task automatic do_reset();
    bus.adj = 1'b0;
    bus.sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Checks the reset state, then runs 75 ticks and expects 01:15.
  task automatic test_reset();
    do_reset();
    check_cnt++;
    if (shown() !== 16'h0000) $display("[TB] FAIL reset_time: got %h want 0000", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b0) $display("[TB] FAIL reset_running: got %b want 0", bus.running);
    else pass_cnt++;
    check_cnt++;
    if (bus.rollover !== 1'b0) $display("[TB] FAIL reset_rollover: got %b want 0", bus.rollover);
    else pass_cnt++;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(75);
    check_cnt++;
    if (shown() !== 16'h0115) $display("[TB] FAIL count_75: got %h want 0115", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b1) $display("[TB] FAIL count_running: got %b want 1", bus.running);
    else pass_cnt++;
  endtask

  // Counts up to 59:59, then checks the wrap and a one-cycle rollover pulse.
  task automatic test_full_wrap();
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(3599);
    check_cnt++;
    if (shown() !== 16'h5959) $display("[TB] FAIL wrap_5959: got %h want 5959", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.rollover !== 1'b0) $display("[TB] FAIL wrap_pre_roll: got %b want 0", bus.rollover);
    else pass_cnt++;
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    check_cnt++;
    if (shown() !== 16'h0000) $display("[TB] FAIL wrap_0000: got %h want 0000", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.rollover !== 1'b1) $display("[TB] FAIL wrap_roll_high: got %b want 1", bus.rollover);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.rollover !== 1'b0) $display("[TB] FAIL wrap_roll_one_clk: got %b want 0", bus.rollover);
    else pass_cnt++;
    run_ticks(1);
    check_cnt++;
    if (shown() !== 16'h0001) $display("[TB] FAIL wrap_0001: got %h want 0001", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.rollover !== 1'b0) $display("[TB] FAIL wrap_post_roll: got %b want 0", bus.rollover);
    else pass_cnt++;
  endtask

  // Pauses at 00:42, clears while paused, then clears together with a tick while running.
  task automatic test_pause_clear();
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(42);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt++;
    if (bus.running !== 1'b0) $display("[TB] FAIL pause_running: got %b want 0", bus.running);
    else pass_cnt++;
    run_ticks(10);
    check_cnt++;
    if (shown() !== 16'h0042) $display("[TB] FAIL pause_hold: got %h want 0042", shown());
    else pass_cnt++;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_cnt++;
    if (shown() !== 16'h0000) $display("[TB] FAIL clear_time: got %h want 0000", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b0) $display("[TB] FAIL clear_running: got %b want 0", bus.running);
    else pass_cnt++;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    check_cnt++;
    if (shown() !== 16'h0000) $display("[TB] FAIL clear_with_tick: got %h want 0000", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b1) $display("[TB] FAIL clear_keeps_run: got %b want 1", bus.running);
    else pass_cnt++;
  endtask

  // Sets 58:30 through adjust, wraps the minutes, wraps the seconds, then
  // checks that tick_1hz is ignored in adjust mode and counting resumes afterwards.
  task automatic test_adjust();
    do_reset();
    bus.adj = 1'b1;
    bus.sel = 1'b0;
    run_ticks_2hz(58);
    bus.sel = 1'b1;
    run_ticks_2hz(30);
    check_cnt++;
    if (shown() !== 16'h5830) $display("[TB] FAIL adj_set_5830: got %h want 5830", shown());
    else pass_cnt++;
    bus.sel = 1'b0;
    run_ticks_2hz(2);
    check_cnt++;
    if (shown() !== 16'h0030) $display("[TB] FAIL adj_min_wrap: got %h want 0030", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.rollover !== 1'b0) $display("[TB] FAIL adj_no_roll: got %b want 0", bus.rollover);
    else pass_cnt++;
    run_ticks_2hz(1);
    check_cnt++;
    if (shown() !== 16'h0130) $display("[TB] FAIL adj_min_0130: got %h want 0130", shown());
    else pass_cnt++;
    bus.sel = 1'b1;
    run_ticks_2hz(31);
    check_cnt++;
    if (shown() !== 16'h0101) $display("[TB] FAIL adj_sec_0101: got %h want 0101", shown());
    else pass_cnt++;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(3);
    check_cnt++;
    if (shown() !== 16'h0101) $display("[TB] FAIL adj_ignores_1hz: got %h want 0101", shown());
    else pass_cnt++;
    bus.adj = 1'b0;
    run_ticks(1);
    check_cnt++;
    if (shown() !== 16'h0102) $display("[TB] FAIL adj_resume: got %h want 0102", shown());
    else pass_cnt++;
    run_ticks_2hz(2);
    check_cnt++;
    if (shown() !== 16'h0102) $display("[TB] FAIL no_adj_2hz_ignored: got %h want 0102", shown());
    else pass_cnt++;
  endtask

  // Applies a pause pulse in the same cycle as a tick, from RUN and from PAUSED.
  task automatic test_simultaneous();
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_cnt++;
    if (shown() !== 16'h0010) $display("[TB] FAIL sim_run_time: got %h want 0010", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b0) $display("[TB] FAIL sim_run_state: got %b want 0", bus.running);
    else pass_cnt++;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_cnt++;
    if (shown() !== 16'h0010) $display("[TB] FAIL sim_pause_time: got %h want 0010", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b1) $display("[TB] FAIL sim_pause_state: got %b want 1", bus.running);
    else pass_cnt++;
    run_ticks(1);
    check_cnt++;
    if (shown() !== 16'h0011) $display("[TB] FAIL sim_after: got %h want 0011", shown());
    else pass_cnt++;
  endtask

  // Checks that asserting reset between clock edges clears the outputs before the next rising edge.
  task automatic test_async_reset();
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(754);
    check_cnt++;
    if (shown() !== 16'h1234) $display("[TB] FAIL async_pre: got %h want 1234", shown());
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (shown() !== 16'h0000) $display("[TB] FAIL async_time: got %h want 0000", shown());
    else pass_cnt++;
    check_cnt++;
    if (bus.running !== 1'b0) $display("[TB] FAIL async_running: got %b want 0", bus.running);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    check_cnt    = 0;
    pass_cnt     = 0;
    rst_n        = 1'b1;
    bus.pause_p  = 1'b0;
    bus.clr_p    = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.tick_2hz = 1'b0;
    bus.adj      = 1'b0;
    bus.sel      = 1'b0;
    test_reset();
    test_full_wrap();
    test_pause_clear();
    test_adjust();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
